// File: rtl/snake_body.sv
// snake_body: ordered segment store for the snake (index 0 = head).
// Accepts new head positions, grows on request, checks head-into-body
// collisions and answers registered display occupancy queries.
// Optional feature macro: SNAKE_SELF_COLLISION_EN (enables the CHECK/DEAD path).
module snake_body #(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned XW       = 4,
  parameter int unsigned YW       = 4,
  parameter int unsigned LW       = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic [XW-1:0] head_x,
  input  logic [YW-1:0] head_y,
  input  logic          grow,
  input  logic [XW-1:0] qx,
  input  logic [YW-1:0] qy,
  output logic          q_hit,
  output logic [LW-1:0] length,
  output logic [XW-1:0] tail_x,
  output logic [YW-1:0] tail_y,
  output logic          busy,
  output logic          game_over
);

  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SHIFT = 2'd2,
    S_DEAD  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  logic [LW-1:0] len_q;
  logic [XW-1:0] hx_q;
  logic [YW-1:0] hy_q;
  logic          grow_q;
  logic          q_hit_q, hit_d;
  logic          latch, shift;
  logic          grow_eff, head_same;
  logic [XW-1:0] tail_x_d;
  logic [YW-1:0] tail_y_d;

`ifdef SNAKE_SELF_COLLISION_EN
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] lim_q, lim_d;
  logic [IW-1:0] lim_start;
  logic          over_q, over_d;
  logic          cur_hit, idx_last;
`endif

  // Move acceptance terms evaluated against the live head segment
  always_comb begin
    grow_eff  = grow && (len_q < LW'(MAX_LEN));
    head_same = (head_x == seg_x_q[0]) && (head_y == seg_y_q[0]);
`ifdef SNAKE_SELF_COLLISION_EN
    // A non-growing move vacates the tail, so the tail is not a collision target
    lim_start = grow_eff ? IW'(len_q) : IW'(len_q - LW'(1));
    cur_hit   = (hx_q == seg_x_q[idx_q]) && (hy_q == seg_y_q[idx_q]);
    idx_last  = (idx_q == lim_q - IW'(1));
`endif
  end

  // Next-state and control decode
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    shift   = 1'b0;
`ifdef SNAKE_SELF_COLLISION_EN
    idx_d   = idx_q;
    lim_d   = lim_q;
    over_d  = over_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (step && !head_same) begin
          latch = 1'b1;
`ifdef SNAKE_SELF_COLLISION_EN
          state_d = S_CHECK;
          idx_d   = '0;
          lim_d   = lim_start;
`else
          state_d = S_SHIFT;
`endif
        end
      end
`ifdef SNAKE_SELF_COLLISION_EN
      S_CHECK: begin
        if (lim_q == '0) begin
          state_d = S_SHIFT;
        end else if (cur_hit) begin
          state_d = S_DEAD;
          over_d  = 1'b1;
        end else if (idx_last) begin
          state_d = S_SHIFT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DEAD: begin
        state_d = S_DEAD;
      end
`endif
      S_SHIFT: begin
        shift   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
`ifdef SNAKE_SELF_COLLISION_EN
      idx_q   <= '0;
      lim_q   <= '0;
      over_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef SNAKE_SELF_COLLISION_EN
      idx_q   <= idx_d;
      lim_q   <= lim_d;
      over_q  <= over_d;
`endif
    end
  end

  // Occupancy of the query cell and tail lookup over live segments
  always_comb begin
    hit_d    = 1'b0;
    tail_x_d = '0;
    tail_y_d = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < len_q) && (seg_x_q[i] == qx) && (seg_y_q[i] == qy)) begin
        hit_d = 1'b1;
      end
      if (LW'(i) == len_q - LW'(1)) begin
        tail_x_d = seg_x_q[i];
        tail_y_d = seg_y_q[i];
      end
    end
  end

  // Segment storage, latched head and registered query result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= '0;
        seg_y_q[i] <= '0;
      end
      len_q   <= LW'(INIT_LEN);
      hx_q    <= '0;
      hy_q    <= '0;
      grow_q  <= 1'b0;
      q_hit_q <= 1'b0;
    end else begin
      q_hit_q <= hit_d;
      if (latch) begin
        hx_q   <= head_x;
        hy_q   <= head_y;
        grow_q <= grow_eff;
      end
      if (shift) begin
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
          seg_x_q[i] <= seg_x_q[i-1];
          seg_y_q[i] <= seg_y_q[i-1];
        end
        seg_x_q[0] <= hx_q;
        seg_y_q[0] <= hy_q;
        len_q      <= len_q + LW'(grow_q);
      end
    end
  end

  assign q_hit  = q_hit_q;
  assign length = len_q;
  assign tail_x = tail_x_d;
  assign tail_y = tail_y_d;
  assign busy   = (state_q == S_CHECK) || (state_q == S_SHIFT);
`ifdef SNAKE_SELF_COLLISION_EN
  assign game_over = over_q;
`else
  assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body; expectations follow the build's
// SNAKE_SELF_COLLISION_EN setting.
module tb_snake_body;

`ifdef SNAKE_SELF_COLLISION_EN
  localparam bit COL = 1'b1;
`else
  localparam bit COL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       step;
  logic [3:0] head_x;
  logic [3:0] head_y;
  logic       grow;
  logic [3:0] qx;
  logic [3:0] qy;
  logic       q_hit;
  logic [4:0] length;
  logic [3:0] tail_x;
  logic [3:0] tail_y;
  logic       busy;
  logic       game_over;

  int vectors = 0;
  int errors  = 0;
  int n;

  snake_body #(.MAX_LEN(16), .INIT_LEN(3), .XW(4), .YW(4), .LW(5)) dut (
    .clk(clk), .reset(reset), .step(step), .head_x(head_x), .head_y(head_y),
    .grow(grow), .qx(qx), .qy(qy), .q_hit(q_hit), .length(length),
    .tail_x(tail_x), .tail_y(tail_y), .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse step with a head, then count sampled busy cycles (bounded)
  task automatic run_step(input int x, input int y, input bit g, output int cnt);
    head_x = 4'(x);
    head_y = 4'(y);
    grow   = g;
    step   = 1'b1;
    tick();
    step = 1'b0;
    grow = 1'b0;
    cnt  = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("busy_bounded", 32'(cnt < 40), 32'd1);
  endtask

  task automatic query(input string tag, input int x, input int y, input bit exp);
    qx = 4'(x);
    qy = 4'(y);
    tick();
    chk(tag, 32'(q_hit), 32'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; step = 1'b0; grow = 1'b0;
    head_x = '0; head_y = '0; qx = '0; qy = '0;

    // Reset state
    tick();
    do_reset();
    chk("rst_length", 32'(length), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_tail_x", 32'(tail_x), 32'd0);
    chk("rst_tail_y", 32'(tail_y), 32'd0);
    query("rst_q00", 0, 0, 1'b1);
    query("rst_q10", 1, 0, 1'b0);

    // Three plain moves along y=0
    run_step(1, 0, 1'b0, n); chk("mv1_busy", 32'(n), COL ? 32'd3 : 32'd1);
    run_step(2, 0, 1'b0, n); chk("mv2_busy", 32'(n), COL ? 32'd3 : 32'd1);
    run_step(3, 0, 1'b0, n); chk("mv3_busy", 32'(n), COL ? 32'd3 : 32'd1);
    chk("mv_length", 32'(length), 32'd3);
    chk("mv_tail_x", 32'(tail_x), 32'd1);
    chk("mv_tail_y", 32'(tail_y), 32'd0);
    query("mv_q30", 3, 0, 1'b1);
    query("mv_q20", 2, 0, 1'b1);
    query("mv_q00", 0, 0, 1'b0);

    // Step with head equal to current head: no-op
    run_step(3, 0, 1'b0, n); chk("noop_busy", 32'(n), 32'd0);
    chk("noop_length", 32'(length), 32'd3);
    chk("noop_tail_x", 32'(tail_x), 32'd1);

    // Grow around a square to length 7, then hit own body at (2,0)
    run_step(4, 0, 1'b1, n); chk("g1_busy", 32'(n), COL ? 32'd4 : 32'd1);
    run_step(4, 1, 1'b1, n); chk("g2_busy", 32'(n), COL ? 32'd5 : 32'd1);
    run_step(3, 1, 1'b1, n); chk("g3_busy", 32'(n), COL ? 32'd6 : 32'd1);
    run_step(2, 1, 1'b1, n); chk("g4_busy", 32'(n), COL ? 32'd7 : 32'd1);
    chk("g_length", 32'(length), 32'd7);
    chk("g_tail_x", 32'(tail_x), 32'd1);
    run_step(2, 0, 1'b0, n); chk("hit_busy", 32'(n), COL ? 32'd6 : 32'd1);
    chk("hit_game_over", 32'(game_over), 32'(COL));
    chk("hit_length", 32'(length), 32'd7);
    chk("hit_tail_x", 32'(tail_x), COL ? 32'd1 : 32'd2);
    run_step(5, 5, 1'b0, n); chk("dead_busy", 32'(n), COL ? 32'd0 : 32'd1);
    chk("dead_tail_x", 32'(tail_x), COL ? 32'd1 : 32'd3);
    chk("dead_game_over", 32'(game_over), 32'(COL));
    query("dead_q55", 5, 5, !COL);

    // Length 4: move into tail without grow is safe, with grow it collides
    do_reset();
    run_step(1, 0, 1'b0, n);
    run_step(2, 0, 1'b0, n);
    run_step(3, 0, 1'b0, n);
    run_step(3, 1, 1'b1, n);
    chk("t_length", 32'(length), 32'd4);
    chk("t_tail_x", 32'(tail_x), 32'd1);
    run_step(1, 0, 1'b0, n); chk("tail_ng_busy", 32'(n), COL ? 32'd4 : 32'd1);
    chk("tail_ng_game_over", 32'(game_over), 32'd0);
    chk("tail_ng_length", 32'(length), 32'd4);
    chk("tail_ng_tail_x", 32'(tail_x), 32'd2);
    run_step(2, 0, 1'b1, n); chk("tail_g_busy", 32'(n), COL ? 32'd4 : 32'd1);
    chk("tail_g_game_over", 32'(game_over), 32'(COL));
    chk("tail_g_length", 32'(length), COL ? 32'd4 : 32'd5);

    // Grow to MAX_LEN and beyond: length saturates, tail drops
    do_reset();
    for (int k = 1; k <= 13; k++) run_step(k, 0, 1'b1, n);
    chk("full_length", 32'(length), 32'd16);
    run_step(14, 0, 1'b1, n); chk("sat_busy", 32'(n), COL ? 32'd16 : 32'd1);
    chk("sat_length", 32'(length), 32'd16);
    run_step(15, 0, 1'b1, n);
    run_step(15, 1, 1'b1, n);
    chk("sat2_length", 32'(length), 32'd16);
    chk("sat2_tail_x", 32'(tail_x), 32'd1);
    chk("sat2_tail_y", 32'(tail_y), 32'd0);
    query("sat_q00", 0, 0, 1'b0);
    query("sat_q151", 15, 1, 1'b1);

    // Asynchronous reset while a move is in flight
    head_x = 4'd14; head_y = 4'd1; grow = 1'b0; step = 1'b1;
    tick();
    step = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_length", 32'(length), 32'd3);
    chk("arst_game_over", 32'(game_over), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    query("arst_q151", 15, 1, 1'b0);
    query("arst_q00", 0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
